// File: rtl/unidad_control.sv
`default_nettype none
// ============================================================================
// Module   : unidad_control
// Purpose  : Sequencer for the radix-2 Booth multiplier datapath (camino_datos).
// Revision : 1.0
// ============================================================================
module unidad_control #(
    parameter int N = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inicio,
    input  logic q0,
    input  logic qsub1,
    output logic reset_dp,
    output logic CargaQ,
    output logic CargaM,
    output logic CargaA,
    output logic resta,
    output logic desplaza,
    output logic fin
);

    localparam int CW = (N < 1) ? 1 : $clog2(N + 1);
    localparam logic [CW-1:0] c_last = CW'(N - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_CHECK = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_reset_dp;
    logic            r_carga_q;
    logic            r_carga_m;
    logic            r_desplaza;
    logic            r_fin;
    logic            w_check;

    // Moore strobes are registered alongside the state they belong to, so
    // each one is set on the transition into its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_reset_dp <= 1'b0;
            r_carga_q  <= 1'b0;
            r_carga_m  <= 1'b0;
            r_desplaza <= 1'b0;
            r_fin      <= 1'b0;
        end else begin
            r_reset_dp <= 1'b0;
            r_carga_q  <= 1'b0;
            r_carga_m  <= 1'b0;
            r_desplaza <= 1'b0;
            r_fin      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (inicio) begin
                        r_state    <= S_CLEAR;
                        r_reset_dp <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_cnt     <= '0;
                    r_state   <= S_LOAD;
                    r_carga_q <= 1'b1;
                    r_carga_m <= 1'b1;
                end
                S_LOAD: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_state    <= S_SHIFT;
                    r_desplaza <= 1'b1;
                end
                S_SHIFT: begin
                    r_cnt <= r_cnt + c_one;
                    if (r_cnt == c_last) begin
                        r_state <= S_DONE;
                        r_fin   <= 1'b1;
                    end else begin
                        r_state <= S_CHECK;
                    end
                end
                S_DONE: begin
                    // Holding inicio keeps the result visible; no retrigger.
                    if (inicio) begin
                        r_fin <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Booth decode is Mealy: it follows the live Q[0]/Q-1 bits during CHECK.
    assign w_check  = (r_state == S_CHECK);
    assign CargaA   = w_check & (q0 ^ qsub1);
    assign resta    = w_check & q0 & ~qsub1;

    assign reset_dp = r_reset_dp;
    assign CargaQ   = r_carga_q;
    assign CargaM   = r_carga_m;
    assign desplaza = r_desplaza;
    assign fin      = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_unidad_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidad_control
// Purpose  : Self-checking bench for unidad_control with a Booth datapath model.
// Revision : 1.0
// ============================================================================
module tb_unidad_control;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic inicio = 1'b0;
    logic q0, qsub1;
    logic reset_dp, CargaQ, CargaM, CargaA, resta, desplaza, fin;

    // Stimulus source for q0/qsub1: datapath model or direct drive
    logic use_model = 1'b0;
    logic drv_q0 = 1'b0;
    logic drv_qsub1 = 1'b0;

    // Datapath model (N=3, A carries one guard bit)
    logic signed [2:0] op_q = 3'sd0;
    logic signed [2:0] op_m = 3'sd0;
    logic [3:0] m_a = '0;
    logic [2:0] m_q = '0;
    logic [2:0] m_m = '0;
    logic       m_qm1 = 1'b0;
    logic [5:0] resultado;

    logic [6:0] outs;
    logic [5:0] sb [$];
    int n_checks = 0;
    int n_pass = 0;
    int cnt_desp = 0;
    int cnt_carga_a = 0;
    int excl_err = 0;

    unidad_control #(.N(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .inicio   (inicio),
        .q0       (q0),
        .qsub1    (qsub1),
        .reset_dp (reset_dp),
        .CargaQ   (CargaQ),
        .CargaM   (CargaM),
        .CargaA   (CargaA),
        .resta    (resta),
        .desplaza (desplaza),
        .fin      (fin)
    );

    always #5 clk = ~clk;

    assign q0        = use_model ? m_q[0] : drv_q0;
    assign qsub1     = use_model ? m_qm1  : drv_qsub1;
    assign resultado = {m_a[2:0], m_q};
    assign outs      = {reset_dp, CargaQ, CargaM, CargaA, resta, desplaza, fin};

    always @(posedge clk) begin
        if (reset_dp) begin
            m_a <= '0; m_q <= '0; m_m <= '0; m_qm1 <= 1'b0;
        end else begin
            if (CargaQ) m_q <= op_q;
            if (CargaM) m_m <= op_m;
            if (CargaA) m_a <= resta ? m_a - {m_m[2], m_m} : m_a + {m_m[2], m_m};
            if (desplaza) {m_a, m_q, m_qm1} <= {m_a[3], m_a, m_q};
        end
    end

    always @(posedge clk) begin
        if (desplaza) cnt_desp++;
        if (CargaA) cnt_carga_a++;
        if ((CargaA & desplaza) | (CargaQ & desplaza) | (resta & ~CargaA)) excl_err++;
    end

    // Start: inicio sampled high at edge 0; returns at the negedge after edge 0.
    task automatic start_run(input logic hold);
        @(negedge clk);
        inicio = 1'b1;
        @(negedge clk);
        if (!hold) inicio = 1'b0;
    endtask

    task automatic wait_fin(output int j);
        j = 0;
        while (fin !== 1'b1 && j < 40) begin
            @(negedge clk);
            j++;
        end
    endtask

    function automatic logic [5:0] booth_ref(input logic signed [2:0] a, input logic signed [2:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[5:0];
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (outs !== 7'b0) $display("FAIL reset_hold: outs=%b expected=%b", outs, 7'b0);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== 7'b0) $display("FAIL reset_idle: outs=%b expected=%b", outs, 7'b0);
        else n_pass++;
    endtask

    task automatic test_full_sequence;
        logic [6:0] exp_seq [10];
        exp_seq = '{7'h40, 7'h30, 7'h00, 7'h02, 7'h00, 7'h02, 7'h00, 7'h02, 7'h01, 7'h00};
        use_model = 1'b0;
        drv_q0 = 1'b0;
        drv_qsub1 = 1'b0;
        cnt_desp = 0;
        start_run(1'b0);
        for (int j = 0; j < 10; j++) begin
            if (j > 0) @(negedge clk);
            n_checks++;
            if (outs !== exp_seq[j]) $display("FAIL seq_j%0d: outs=%b expected=%b", j, outs, exp_seq[j]);
            else n_pass++;
        end
        n_checks++;
        if (cnt_desp !== 3) $display("FAIL desplaza_count: got=%0d expected=3", cnt_desp);
        else n_pass++;
    endtask

    task automatic test_check_decode;
        logic [1:0] pat [4];
        logic [1:0] exp_ar [4];
        pat    = '{2'b10, 2'b01, 2'b00, 2'b11};
        exp_ar = '{2'b11, 2'b10, 2'b00, 2'b00};
        use_model = 1'b0;
        for (int i = 0; i < 4; i++) begin
            {drv_q0, drv_qsub1} = pat[i];
            start_run(1'b0);
            repeat (2) @(negedge clk);
            n_checks++;
            if ({CargaA, resta} !== exp_ar[i])
                $display("FAIL decode_%b: CargaA,resta=%b expected=%b", pat[i], {CargaA, resta}, exp_ar[i]);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({CargaA, desplaza} !== 2'b01)
                $display("FAIL decode_shift_%b: CargaA,desplaza=%b expected=01", pat[i], {CargaA, desplaza});
            else n_pass++;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    task automatic test_integration;
        logic [2:0] qv [4];
        logic [2:0] mv [4];
        logic [5:0] exp_r;
        int lat;
        qv = '{3'b011, 3'b011, 3'b100, 3'b000};
        mv = '{3'b011, 3'b100, 3'b100, 3'b011};
        use_model = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_q = qv[i];
            op_m = mv[i];
            sb.push_back(booth_ref(op_q, op_m));
            cnt_carga_a = 0;
            start_run(1'b0);
            wait_fin(lat);
            n_checks++;
            if (lat !== 8) $display("FAIL latency_%0d: got=%0d expected=8", i, lat);
            else n_pass++;
            exp_r = (sb.size() > 0) ? sb.pop_front() : 6'bx;
            n_checks++;
            if (resultado !== exp_r)
                $display("FAIL result_q%b_m%b: got=%b expected=%b", qv[i], mv[i], resultado, exp_r);
            else n_pass++;
            if (qv[i] == 3'b000) begin
                n_checks++;
                if (cnt_carga_a !== 0) $display("FAIL carga_a_zero: got=%0d expected=0", cnt_carga_a);
                else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_held;
        logic [5:0] exp_r;
        int lat;
        use_model = 1'b1;
        op_q = 3'sb011;
        op_m = 3'sb101;
        sb.push_back(booth_ref(op_q, op_m));
        start_run(1'b1);
        wait_fin(lat);
        n_checks++;
        if (lat !== 8) $display("FAIL held_latency: got=%0d expected=8", lat);
        else n_pass++;
        exp_r = (sb.size() > 0) ? sb.pop_front() : 6'bx;
        n_checks++;
        if (resultado !== exp_r) $display("FAIL held_result: got=%b expected=%b", resultado, exp_r);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (outs !== 7'h01) $display("FAIL held_done_%0d: outs=%b expected=%b", k, outs, 7'h01);
            else n_pass++;
        end
        inicio = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs !== 7'h00) $display("FAIL held_release: outs=%b expected=%b", outs, 7'h00);
        else n_pass++;
        op_q = 3'sb110;
        op_m = 3'sb011;
        sb.push_back(booth_ref(op_q, op_m));
        start_run(1'b0);
        n_checks++;
        if (reset_dp !== 1'b1) $display("FAIL restart_clear: reset_dp=%b expected=1", reset_dp);
        else n_pass++;
        wait_fin(lat);
        exp_r = (sb.size() > 0) ? sb.pop_front() : 6'bx;
        n_checks++;
        if (lat !== 8 || resultado !== exp_r)
            $display("FAIL restart_result: lat=%0d result=%b expected lat=8 result=%b", lat, resultado, exp_r);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_states;
        logic [5:0] exp_r;
        int lat;
        use_model = 1'b1;
        op_q = 3'sb101;
        op_m = 3'sb110;
        for (int k = 0; k < 9; k++) begin
            start_run(1'b0);
            repeat (k) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            n_checks++;
            if (outs !== 7'h00) $display("FAIL reset_at_j%0d: outs=%b expected=%b", k, outs, 7'h00);
            else n_pass++;
            reset = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (outs !== 7'h00) $display("FAIL reset_then_idle: outs=%b expected=%b", outs, 7'h00);
        else n_pass++;
        sb.push_back(booth_ref(op_q, op_m));
        start_run(1'b0);
        wait_fin(lat);
        exp_r = (sb.size() > 0) ? sb.pop_front() : 6'bx;
        n_checks++;
        if (lat !== 8 || resultado !== exp_r)
            $display("FAIL post_reset_run: lat=%0d result=%b expected lat=8 result=%b", lat, resultado, exp_r);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_exclusion;
        n_checks++;
        if (excl_err !== 0) $display("FAIL strobe_exclusion: violations=%0d expected=0", excl_err);
        else n_pass++;
        n_checks++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain: pending=%0d expected=0", sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_check_decode();
        test_integration();
        test_start_held();
        test_reset_states();
        test_exclusion();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks passed=%0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
